// File: rtl/cu_bus_connect_pkg.sv
// Shared definitions for the compute-unit bus-connect block: default widths
// and the DM transaction sequencer state encoding.
package cu_bc_pkg;

    localparam int BC_RF_DATASIZE      = 32;
    localparam int BC_ADDRESS_WIDTH    = 4;
    localparam int BC_DM_ADDRESS_WIDTH = 16;
    localparam int BC_SB_DEPTH_LOG2    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_WAIT = 2'd1,
        LD_WAIT = 2'd2,
        LD_WB   = 2'd3
    } bc_state_t;

endpackage

// File: rtl/cu_bus_connect_store_fifo.sv
// Posted store buffer: circular synchronous FIFO with wrap-around pointers.
// A push while full is dropped, so the caller must gate it with full.
module bc_store_fifo
    import cu_bc_pkg::*;
#(
    parameter int WIDTH      = BC_DM_ADDRESS_WIDTH + BC_RF_DATASIZE,
    parameter int DEPTH_LOG2 = BC_SB_DEPTH_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      storage [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count == COUNT_FULL);
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = storage[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + COUNT_ONE;
            else if (!do_push && do_pop) count <= count - COUNT_ONE;
        end
    end

    // Entry storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cu_bus_connect.sv
// Bus-connect between the CU register-file port pair and data memory.
// Stores are posted through a small buffer; loads wait for the buffer to
// drain so a load always observes every earlier store.
module cu_bus_connect
    import cu_bc_pkg::*;
#(
    parameter int RF_DATASIZE      = BC_RF_DATASIZE,
    parameter int ADDRESS_WIDTH    = BC_ADDRESS_WIDTH,
    parameter int DM_ADDRESS_WIDTH = BC_DM_ADDRESS_WIDTH,
    parameter int SB_DEPTH_LOG2    = BC_SB_DEPTH_LOG2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ps_bc_st,
    input  logic [DM_ADDRESS_WIDTH-1:0] ps_bc_st_addr,
    input  logic [RF_DATASIZE-1:0]      xb_dtx,
    input  logic                        ps_bc_ld,
    input  logic [DM_ADDRESS_WIDTH-1:0] ps_bc_ld_addr,
    input  logic [ADDRESS_WIDTH-1:0]    ps_bc_ld_rd,
    output logic                        bc_ps_stall,
    output logic [RF_DATASIZE-1:0]      bc_dt,
    output logic                        bc_xb_w_En,
    output logic [ADDRESS_WIDTH-1:0]    bc_xb_wadd,
    output logic                        dm_req,
    output logic                        dm_we,
    output logic [DM_ADDRESS_WIDTH-1:0] dm_addr,
    output logic [RF_DATASIZE-1:0]      dm_wdata,
    input  logic                        dm_ack,
    input  logic [RF_DATASIZE-1:0]      dm_rdata
);

    localparam int SB_WIDTH = DM_ADDRESS_WIDTH + RF_DATASIZE;

    bc_state_t                   state;
    logic                        sb_full;
    logic                        sb_empty;
    logic                        sb_push;
    logic                        sb_pop;
    logic [SB_WIDTH-1:0]         sb_head;
    logic [DM_ADDRESS_WIDTH-1:0] head_addr;
    logic [RF_DATASIZE-1:0]      head_wdata;
    logic                        ld_pending;
    logic                        ld_accept;
    logic [DM_ADDRESS_WIDTH-1:0] ld_addr;
    logic [ADDRESS_WIDTH-1:0]    ld_rd;

    assign bc_ps_stall             = sb_full | ld_pending;
    assign sb_push                 = ps_bc_st & ~bc_ps_stall;
    assign ld_accept               = ps_bc_ld & ~bc_ps_stall;
    assign sb_pop                  = (state == ST_WAIT) & dm_ack;
    assign {head_addr, head_wdata} = sb_head;

    bc_store_fifo #(
        .WIDTH      (SB_WIDTH),
        .DEPTH_LOG2 (SB_DEPTH_LOG2)
    ) u_store_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (sb_push),
        .push_data ({ps_bc_st_addr, xb_dtx}),
        .pop       (sb_pop),
        .head_data (sb_head),
        .full      (sb_full),
        .empty     (sb_empty)
    );

    // DM sequencer: drain stores first, then the pending load, then write it back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            bc_dt      <= '0;
            bc_xb_w_En <= 1'b0;
            bc_xb_wadd <= '0;
            ld_pending <= 1'b0;
            ld_addr    <= '0;
            ld_rd      <= '0;
        end else begin
            bc_xb_w_En <= 1'b0;
            if (ld_accept) begin
                ld_pending <= 1'b1;
                ld_addr    <= ps_bc_ld_addr;
                ld_rd      <= ps_bc_ld_rd;
            end
            case (state)
                IDLE: begin
                    if (!sb_empty) begin
                        dm_req   <= 1'b1;
                        dm_we    <= 1'b1;
                        dm_addr  <= head_addr;
                        dm_wdata <= head_wdata;
                        state    <= ST_WAIT;
                    end else if (ld_pending) begin
                        dm_req  <= 1'b1;
                        dm_we   <= 1'b0;
                        dm_addr <= ld_addr;
                        state   <= LD_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        state  <= IDLE;
                    end
                end
                LD_WAIT: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        bc_dt  <= dm_rdata;
                        state  <= LD_WB;
                    end
                end
                LD_WB: begin
                    bc_xb_w_En <= 1'b1;
                    bc_xb_wadd <= ld_rd;
                    ld_pending <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_bus_connect.sv
// Self-checking bench for cu_bus_connect: a transaction-level model (store
// queue, pending-load record, associative DM image) predicts every output.
module tb_cu_bus_connect;

    localparam int DS       = 32;
    localparam int AW       = 4;
    localparam int DAW      = 16;
    localparam int SB_DEPTH = 4;

    logic           clk;
    logic           reset;
    logic           ps_bc_st;
    logic [DAW-1:0] ps_bc_st_addr;
    logic [DS-1:0]  xb_dtx;
    logic           ps_bc_ld;
    logic [DAW-1:0] ps_bc_ld_addr;
    logic [AW-1:0]  ps_bc_ld_rd;
    logic           bc_ps_stall;
    logic [DS-1:0]  bc_dt;
    logic           bc_xb_w_En;
    logic [AW-1:0]  bc_xb_wadd;
    logic           dm_req;
    logic           dm_we;
    logic [DAW-1:0] dm_addr;
    logic [DS-1:0]  dm_wdata;
    logic           dm_ack;
    logic [DS-1:0]  dm_rdata;

    cu_bus_connect dut (
        .clk           (clk),
        .reset         (reset),
        .ps_bc_st      (ps_bc_st),
        .ps_bc_st_addr (ps_bc_st_addr),
        .xb_dtx        (xb_dtx),
        .ps_bc_ld      (ps_bc_ld),
        .ps_bc_ld_addr (ps_bc_ld_addr),
        .ps_bc_ld_rd   (ps_bc_ld_rd),
        .bc_ps_stall   (bc_ps_stall),
        .bc_dt         (bc_dt),
        .bc_xb_w_En    (bc_xb_w_En),
        .bc_xb_wadd    (bc_xb_wadd),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_ack        (dm_ack),
        .dm_rdata      (dm_rdata)
    );

    int checks = 0;
    int failures = 0;

    // Model state
    logic [DAW+DS-1:0] st_q[$];
    logic [DS-1:0]     mem[logic [DAW-1:0]];
    bit                ld_pend;
    logic [DAW-1:0]    ld_a;
    logic [AW-1:0]     ld_r;
    int                wb_cnt;
    logic [DS-1:0]     exp_dt;
    bit                just_acked;
    int                req_age;
    int                idle_cnt;

    // Stimulus / responder controls and observation logs
    bit             want_st, want_ld;
    logic [DAW-1:0] w_sa, w_la;
    logic [DS-1:0]  w_sd;
    logic [AW-1:0]  w_lr;
    bit             ack_en, rand_ack, spur_en, force_spur;
    int             ack_delay;
    int             cyc, st_acc, ld_acc_cyc, wen_cyc;
    logic [AW-1:0]  obs_wadd;
    logic [DS-1:0]  obs_dt, obs_req_wdata;
    logic           obs_stall;
    logic [DAW:0]   txn_log[$];
    logic [DAW-1:0] wr_log[$];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit st, input logic [DAW-1:0] sa, input logic [DS-1:0] sd,
                                 input bit ld, input logic [DAW-1:0] la, input logic [AW-1:0] lr);
        if (st) begin want_st = 1; w_sa = sa; w_sd = sd; end
        if (ld) begin want_ld = 1; w_la = la; w_lr = lr; end
    endtask

    function automatic logic [DS-1:0] mem_rd(input logic [DAW-1:0] a);
        return mem.exists(a) ? mem[a] : {16'hC0DE, a};
    endfunction

    task automatic clearModel();
        st_q.delete();
        ld_pend = 0; wb_cnt = 0; exp_dt = '0; just_acked = 0;
        req_age = 0; idle_cnt = 0; want_st = 0; want_ld = 0;
    endtask

    // One cycle: compare at the falling edge, then respond and drive for the next rising edge.
    task automatic tick();
        bit exp_wen, exp_stall, work, ack_now;
        logic [DAW-1:0] ha;
        logic [DS-1:0]  hd;
        @(negedge clk);
        cyc++;
        exp_wen = 0;
        if (wb_cnt > 0) begin
            wb_cnt--;
            if (wb_cnt == 0) begin exp_wen = 1; ld_pend = 0; end
        end
        exp_stall = (st_q.size() == SB_DEPTH) || ld_pend;
        checkOutput("stall", 64'(bc_ps_stall), 64'(exp_stall));
        checkOutput("w_en", 64'(bc_xb_w_En), 64'(exp_wen));
        checkOutput("bc_dt", 64'(bc_dt), 64'(exp_dt));
        if (exp_wen) begin
            checkOutput("wadd", 64'(bc_xb_wadd), 64'(ld_r));
            obs_wadd = bc_xb_wadd; obs_dt = bc_dt; obs_stall = bc_ps_stall; wen_cyc = cyc;
        end
        work = (st_q.size() > 0) || (ld_pend && wb_cnt == 0);
        if (just_acked) begin
            checkOutput("req_gap", 64'(dm_req), 64'd0);
        end else if (dm_req) begin
            if (req_age == 0) begin
                txn_log.push_back({dm_we, dm_addr});
                obs_req_wdata = dm_wdata;
            end
            if (st_q.size() > 0) begin
                {ha, hd} = st_q[0];
                checkOutput("st_we", 64'(dm_we), 64'd1);
                checkOutput("st_addr", 64'(dm_addr), 64'(ha));
                checkOutput("st_wdata", 64'(dm_wdata), 64'(hd));
            end else if (work) begin
                checkOutput("ld_we", 64'(dm_we), 64'd0);
                checkOutput("ld_addr", 64'(dm_addr), 64'(ld_a));
            end else begin
                checkOutput("req_unexpected", 64'(dm_req), 64'd0);
            end
        end
        if (work && !dm_req && !just_acked) idle_cnt++;
        else idle_cnt = 0;
        checkOutput("issue_bound", 64'(idle_cnt <= 2), 64'd1);

        dm_ack = 0;
        dm_rdata = $urandom;
        ack_now = 0;
        if (dm_req && !just_acked && work) begin
            if (req_age == 0 && rand_ack) ack_delay = $urandom_range(0, 3);
            if (ack_en && req_age >= ack_delay) begin
                dm_ack = 1; ack_now = 1; req_age = 0;
                if (st_q.size() > 0) begin
                    {ha, hd} = st_q.pop_front();
                    mem[ha] = hd;
                    wr_log.push_back(dm_addr);
                end else begin
                    dm_rdata = mem_rd(ld_a);
                    exp_dt = dm_rdata;
                    wb_cnt = 2;
                end
            end else begin
                req_age++;
            end
        end else if (!dm_req && (force_spur || (spur_en && $urandom_range(0, 9) == 0))) begin
            dm_ack = 1;
        end
        just_acked = ack_now;

        ps_bc_st = want_st; ps_bc_st_addr = w_sa; xb_dtx = w_sd;
        ps_bc_ld = want_ld; ps_bc_ld_addr = w_la; ps_bc_ld_rd = w_lr;
        if (!exp_stall) begin
            if (want_st) begin st_q.push_back({w_sa, w_sd}); st_acc++; want_st = 0; end
            if (want_ld) begin ld_pend = 1; ld_a = w_la; ld_r = w_lr; ld_acc_cyc = cyc; want_ld = 0; end
        end
    endtask

    // Directed scenarios followed by a randomized soak
    initial begin
        int hold_cnt;
        reset = 0; dm_ack = 0; dm_rdata = '0;
        ps_bc_st = 0; ps_bc_st_addr = '0; xb_dtx = '0;
        ps_bc_ld = 0; ps_bc_ld_addr = '0; ps_bc_ld_rd = '0;
        w_sa = '0; w_sd = '0; w_la = '0; w_lr = '0; ld_a = '0; ld_r = '0;
        ack_en = 1; rand_ack = 0; spur_en = 0; force_spur = 0; ack_delay = 0;
        cyc = 0; st_acc = 0; ld_acc_cyc = 0; wen_cyc = 0;
        clearModel();
        tick(); tick();
        reset = 1;

        // 1: reset values, then a stray ack while idle
        tick(); tick();
        checkOutput("t1_dm_req", 64'(dm_req), 64'd0);
        checkOutput("t1_dm_we", 64'(dm_we), 64'd0);
        checkOutput("t1_dm_addr", 64'(dm_addr), 64'd0);
        checkOutput("t1_dm_wdata", 64'(dm_wdata), 64'd0);
        checkOutput("t1_bc_dt", 64'(bc_dt), 64'd0);
        checkOutput("t1_w_en", 64'(bc_xb_w_En), 64'd0);
        checkOutput("t1_wadd", 64'(bc_xb_wadd), 64'd0);
        checkOutput("t1_stall", 64'(bc_ps_stall), 64'd0);
        force_spur = 1; tick(); force_spur = 0; tick(); tick();
        checkOutput("t1_spur_req", 64'(dm_req), 64'd0);
        checkOutput("t1_spur_dt", 64'(bc_dt), 64'd0);
        checkOutput("t1_spur_wen", 64'(bc_xb_w_En), 64'd0);

        // 2: single store, acked on the third request cycle
        txn_log.delete(); wr_log.delete(); ack_delay = 2; hold_cnt = 0;
        applyStimulus(1, 16'h0010, 32'hDEADBEEF, 0, '0, '0);
        for (int k = 0; k < 20 && wr_log.size() == 0; k++) begin
            tick();
            if (dm_req) hold_cnt++;
        end
        tick();
        checkOutput("t2_txn", 64'(txn_log.size() > 0 ? txn_log[0] : '0), 64'h1_0010);
        checkOutput("t2_wdata", 64'(obs_req_wdata), 64'hDEADBEEF);
        checkOutput("t2_req_cycles", 64'(hold_cnt), 64'd3);
        checkOutput("t2_req_dropped", 64'(dm_req), 64'd0);

        // 3: fill the buffer with DM stalled, then drain in order
        ack_delay = 0; ack_en = 0; st_acc = 0; wr_log.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 16'h0100 + 16'(i), 32'hC0000000 + 32'(i), 0, '0, '0);
            tick();
        end
        checkOutput("t3_accepts4", 64'(st_acc), 64'd4);
        tick();
        checkOutput("t3_stall_full", 64'(bc_ps_stall), 64'd1);
        applyStimulus(1, 16'h0104, 32'hC0000004, 0, '0, '0);
        repeat (4) tick();
        checkOutput("t3_fifth_held", 64'(st_acc), 64'd4);
        ack_en = 1;
        for (int k = 0; k < 60 && (st_q.size() > 0 || want_st); k++) tick();
        tick();
        checkOutput("t3_accepts5", 64'(st_acc), 64'd5);
        checkOutput("t3_drained", 64'(wr_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++)
            checkOutput("t3_order", 64'(wr_log[i]), 64'h0100 + 64'(i));

        // 4: load latency with immediate ack
        mem[16'h0020] = 32'h12345678; wen_cyc = 0;
        applyStimulus(0, '0, '0, 1, 16'h0020, 4'd3);
        tick();
        for (int k = 0; k < 12 && wen_cyc == 0; k++) tick();
        checkOutput("t4_latency", 64'(wen_cyc - ld_acc_cyc), 64'd4);
        checkOutput("t4_wadd", 64'(obs_wadd), 64'd3);
        checkOutput("t4_dt", 64'(obs_dt), 64'h12345678);
        checkOutput("t4_stall", 64'(obs_stall), 64'd0);
        tick();
        checkOutput("t4_wen_one_cycle", 64'(bc_xb_w_En), 64'd0);

        // 5: same-cycle store and load to one address
        txn_log.delete(); wen_cyc = 0;
        applyStimulus(1, 16'h0030, 32'hA5A5A5A5, 1, 16'h0030, 4'd7);
        for (int k = 0; k < 20 && wen_cyc == 0; k++) tick();
        checkOutput("t5_first", 64'(txn_log.size() > 0 ? txn_log[0] : '0), 64'h1_0030);
        checkOutput("t5_second", 64'(txn_log.size() > 1 ? txn_log[1] : '0), 64'h0_0030);
        checkOutput("t5_dt", 64'(obs_dt), 64'hA5A5A5A5);
        checkOutput("t5_wadd", 64'(obs_wadd), 64'd7);

        // 6: reset while a read is outstanding, then a clean load
        ack_en = 0; tick();
        applyStimulus(0, '0, '0, 1, 16'h0044, 4'd5);
        for (int k = 0; k < 10 && !(dm_req && !dm_we); k++) tick();
        checkOutput("t6_in_read", 64'({dm_req, dm_we}), 64'b10);
        #2 reset = 0;
        #1;
        checkOutput("t6_req_drop", 64'(dm_req), 64'd0);
        checkOutput("t6_stall", 64'(bc_ps_stall), 64'd0);
        checkOutput("t6_wen", 64'(bc_xb_w_En), 64'd0);
        clearModel();
        tick(); tick();
        reset = 1; ack_en = 1;
        mem[16'h0044] = 32'h0BADF00D; wen_cyc = 0;
        applyStimulus(0, '0, '0, 1, 16'h0044, 4'd5);
        for (int k = 0; k < 12 && wen_cyc == 0; k++) tick();
        checkOutput("t6_dt", 64'(obs_dt), 64'h0BADF00D);
        checkOutput("t6_wadd", 64'(obs_wadd), 64'd5);

        // Randomized soak over a small address window to exercise store-to-load ordering
        rand_ack = 1; spur_en = 1;
        for (int i = 0; i < 1500; i++) begin
            if (!want_st && $urandom_range(0, 9) < 3)
                applyStimulus(1, 16'h0200 + 16'($urandom_range(0, 7)), 32'($urandom), 0, '0, '0);
            if (!want_ld && $urandom_range(0, 19) < 3)
                applyStimulus(0, '0, '0, 1, 16'h0200 + 16'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            tick();
        end
        for (int k = 0; k < 200 && (want_st || want_ld || st_q.size() > 0 || ld_pend || wb_cnt > 0); k++) tick();
        tick();
        checkOutput("drain_done", 64'(st_q.size() + int'(ld_pend) + int'(want_st) + int'(want_ld)), 64'd0);
        checkOutput("end_req", 64'(dm_req), 64'd0);
        checkOutput("end_stall", 64'(bc_ps_stall), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
